// File: rtl/sram_fifo_reader_if.sv
// Stream-side and FIFO-side signal bundle for sram_fifo_reader.
// master is the reader's view; slave is the FIFO/consumer environment's view.
interface sram_fifo_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic                  fifo_pop_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_pop_o, out_valid_o, out_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_pop_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/sram_fifo_reader.sv
// Drains a BRAM-backed FIFO through a skid buffer onto a valid/ready stream.
// Define SRAM_FIFO_READER_DO_REG_EN when the FIFO has its output register (read latency 2).
module sram_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  sram_fifo_reader_if.master   bus,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 idle_o
);
`ifdef SRAM_FIFO_READER_DO_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int BUF_DEPTH = RD_LAT + 2;

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [2:0]            buf_cnt;
  logic [RD_LAT-1:0]     trk;
  logic [2:0]            inflight;
  logic                  flush_q;
  logic                  pop;
  logic                  capture;
  logic                  handshake;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {2'b00, trk[i]};
    end
  end

  // Reserving room for every word already in flight makes overflow impossible.
  assign pop = !rst_i && !bus.fifo_empty_i && !flush_i && !flush_q &&
               ((buf_cnt + inflight) < 3'(BUF_DEPTH));
  assign capture   = trk[RD_LAT-1];
  assign handshake = (buf_cnt != 3'd0) && bus.out_ready_i;

  assign bus.fifo_pop_o  = pop;
  assign bus.out_valid_o = (buf_cnt != 3'd0);
  assign bus.out_data_o  = buf_mem[head];
  assign idle_o          = (buf_cnt == 3'd0) && (inflight == 3'd0) && bus.fifo_empty_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head    <= '0;
      tail    <= '0;
      buf_cnt <= '0;
      trk     <= '0;
      flush_q <= 1'b0;
      count_o <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      flush_q <= flush_i;
      if (handshake) begin
        count_o <= count_o + CNT_WIDTH'(1);
      end
      // A flush drops both buffered words and whatever the FIFO is still returning.
      if (flush_i) begin
        head    <= '0;
        tail    <= '0;
        buf_cnt <= '0;
        trk     <= '0;
      end else begin
        trk <= RD_LAT'({trk, pop});
        if (capture) begin
          buf_mem[tail] <= bus.fifo_data_i;
          tail          <= wrap_inc(tail);
        end
        if (handshake) begin
          head <= wrap_inc(head);
        end
        case ({capture, handshake})
          2'b10:   buf_cnt <= buf_cnt + 3'd1;
          2'b01:   buf_cnt <= buf_cnt - 3'd1;
          default: buf_cnt <= buf_cnt;
        endcase
      end
    end
  end
endmodule
